// File: rtl/char_pixel_shifter.sv
// Glyph serialiser with fg/bg/blink colouring and pixel-aligned blank/sync delay.
// Optional inverse-video cursor cell is enabled by defining SHIFTER_CURSOR_EN.
module char_pixel_shifter #(
    parameter int PIPE_DEPTH   = 1,
    parameter int BLINK_PERIOD = 16
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       shload_n,
    input  logic [7:0] pix_data,
    input  logic [7:0] attr,
    input  logic       blank_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       cursor_hit,
    output logic [3:0] color,
    output logic       blank_out,
    output logic       hsync_out,
    output logic       vsync_out
);

    localparam logic [4:0] FRAME_LAST = 5'(BLINK_PERIOD - 1);

    logic [7:0]            sh;
    logic [7:0]            attr_q;
    logic [PIPE_DEPTH-1:0] blank_p;
    logic [PIPE_DEPTH-1:0] hs_p;
    logic [PIPE_DEPTH-1:0] vs_p;
    logic                  vs_q;
    logic [4:0]            frame_cnt;
    logic                  blink_phase;
    logic [3:0]            fg_eff;
    logic [3:0]            bg_eff;
    logic [3:0]            pix_color;
    logic                  blank_d;

`ifdef SHIFTER_CURSOR_EN
    logic cur_q;
`else
    logic unused_cursor;
    assign unused_cursor = cursor_hit;
`endif

    assign blank_d = blank_p[PIPE_DEPTH-1];

    always_ff @(posedge pclk) begin
        if (rst) begin
            sh     <= 8'h00;
            attr_q <= 8'h00;
`ifdef SHIFTER_CURSOR_EN
            cur_q  <= 1'b0;
`endif
        end else if (!shload_n) begin
            sh     <= pix_data;
            attr_q <= attr;
`ifdef SHIFTER_CURSOR_EN
            cur_q  <= cursor_hit;
`endif
        end else begin
            sh <= {sh[6:0], 1'b0};
        end
    end

    // Blink applies first; the cursor swap then works on the blinked pair
    always_comb begin
        bg_eff = {1'b0, attr_q[6:4]};
        fg_eff = attr_q[3:0];
        if (attr_q[7] && blink_phase) begin
            fg_eff = bg_eff;
        end
`ifdef SHIFTER_CURSOR_EN
        if (cur_q && !blink_phase) begin
            fg_eff = bg_eff;
            bg_eff = attr_q[7] && blink_phase ? {1'b0, attr_q[6:4]}
                                              : attr_q[3:0];
        end
`endif
        pix_color = sh[7] ? fg_eff : bg_eff;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            blank_p <= '1;
            hs_p    <= '0;
            vs_p    <= '0;
        end else begin
            blank_p[0] <= blank_in;
            hs_p[0]    <= hsync_in;
            vs_p[0]    <= vsync_in;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                blank_p[i] <= blank_p[i-1];
                hs_p[i]    <= hs_p[i-1];
                vs_p[i]    <= vs_p[i-1];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            color     <= 4'h0;
            blank_out <= 1'b1;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            color     <= blank_d ? 4'h0 : pix_color;
            blank_out <= blank_d;
            hsync_out <= hs_p[PIPE_DEPTH-1];
            vsync_out <= vs_p[PIPE_DEPTH-1];
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_q        <= 1'b0;
            frame_cnt   <= 5'd0;
            blink_phase <= 1'b0;
        end else begin
            vs_q <= vsync_in;
            if (vsync_in && !vs_q) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= 5'd0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 5'd1;
                end
            end
        end
    end

endmodule
